// File: rtl/startup_sequencer.sv
// Startup sequencer: on entry to the management STARTUP op state, starts each startup-capable
// submodule in fixed order, waits for its done under a watchdog, and reports done/fail.
module startup_sequencer #(
    parameter int NUM_SUB        = 5,
    parameter int TIMER_W        = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [2:0]         op_state,
    input  logic [2:0]         startup_type,
    input  logic [NUM_SUB-1:0] sub_done,
    output logic [NUM_SUB-1:0] sub_start,
    output logic [2:0]         sub_type,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               seq_fail,
    output logic [2:0]         fail_index
);

    localparam int IDX_W = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
    localparam logic [2:0]         STARTUP_STATE = 3'b010;
    localparam logic [2:0]         INVALID_INDEX = 3'd7;
    localparam logic [IDX_W-1:0]   LAST_IDX      = IDX_W'(NUM_SUB - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_SUB-1:0] ONE_HOT0      = {{(NUM_SUB-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_s;
    logic [2:0]         sub_type_r;
    logic [2:0]         sub_type_s;
    logic [2:0]         fail_index_r;
    logic [2:0]         fail_index_s;
    logic [NUM_SUB-1:0] sub_start_r;
    logic               seq_busy_r;
    logic               seq_done_r;
    logic               seq_fail_r;
    logic               in_startup_s;
    logic               type_ok_s;

    assign in_startup_s = (op_state == STARTUP_STATE);
    assign type_ok_s    = (startup_type == 3'd1) || (startup_type == 3'd2) ||
                          (startup_type == 3'd3);

    // Next-state, index, watchdog and latched-field logic.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        timer_s      = timer_r;
        sub_type_s   = sub_type_r;
        fail_index_s = fail_index_r;
        case (state_r)
            ST_IDLE: begin
                idx_s        = {IDX_W{1'b0}};
                timer_s      = {TIMER_W{1'b0}};
                sub_type_s   = 3'd0;
                fail_index_s = 3'd0;
                if (in_startup_s && type_ok_s) begin
                    state_s    = ST_ISSUE;
                    sub_type_s = startup_type;
                end else if (in_startup_s) begin
                    state_s      = ST_FAIL;
                    fail_index_s = INVALID_INDEX;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!in_startup_s) begin
                    state_s      = ST_IDLE;
                    idx_s        = {IDX_W{1'b0}};
                    timer_s      = {TIMER_W{1'b0}};
                    sub_type_s   = 3'd0;
                    fail_index_s = 3'd0;
                end else begin
                    state_s = ST_WAIT;
                    timer_s = {TIMER_W{1'b0}};
                end
            end
            ST_WAIT: begin
                // Abort beats done, and done beats a coincident timeout.
                if (!in_startup_s) begin
                    state_s      = ST_IDLE;
                    idx_s        = {IDX_W{1'b0}};
                    timer_s      = {TIMER_W{1'b0}};
                    sub_type_s   = 3'd0;
                    fail_index_s = 3'd0;
                end else if (sub_done[idx_r] && (idx_r == LAST_IDX)) begin
                    state_s = ST_DONE;
                end else if (sub_done[idx_r]) begin
                    state_s = ST_ISSUE;
                    idx_s   = idx_r + IDX_W'(1);
                end else if (timer_r == TIMEOUT_LAST) begin
                    state_s      = ST_FAIL;
                    fail_index_s = 3'(idx_r);
                end else begin
                    timer_s = timer_r + TIMER_W'(1);
                end
            end
            ST_DONE, ST_FAIL: begin
                if (!in_startup_s) begin
                    state_s      = ST_IDLE;
                    idx_s        = {IDX_W{1'b0}};
                    timer_s      = {TIMER_W{1'b0}};
                    sub_type_s   = 3'd0;
                    fail_index_s = 3'd0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                idx_s        = {IDX_W{1'b0}};
                timer_s      = {TIMER_W{1'b0}};
                sub_type_s   = 3'd0;
                fail_index_s = 3'd0;
            end
        endcase
    end

    // State, counters and outputs; outputs are registered from the next-state decode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            timer_r      <= {TIMER_W{1'b0}};
            sub_type_r   <= 3'd0;
            fail_index_r <= 3'd0;
            sub_start_r  <= {NUM_SUB{1'b0}};
            seq_busy_r   <= 1'b0;
            seq_done_r   <= 1'b0;
            seq_fail_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            timer_r      <= timer_s;
            sub_type_r   <= sub_type_s;
            fail_index_r <= fail_index_s;
            sub_start_r  <= (state_s == ST_ISSUE) ? (ONE_HOT0 << idx_s) : {NUM_SUB{1'b0}};
            seq_busy_r   <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
            seq_done_r   <= (state_s == ST_DONE);
            seq_fail_r   <= (state_s == ST_FAIL);
        end
    end

    assign sub_start  = sub_start_r;
    assign sub_type   = sub_type_r;
    assign seq_busy   = seq_busy_r;
    assign seq_done   = seq_done_r;
    assign seq_fail   = seq_fail_r;
    assign fail_index = fail_index_r;

endmodule
